// File: rtl/axi_read_arbiter_if.sv
// Bundles the two requester AR/R ports and the memory-side AR/R port of the
// read arbiter. The "slave" modport is the arbiter's view. The "master"
// modport is the view of the environment, which drives the requests and the
// memory responses.
//   s0_* / s1_*  : ICache / DCache requester AR + R channels
//   m_axi_*      : shared memory-side AR + R channels
interface axi_read_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 13
);
    // requester 0 (ICache)
    logic                  s0_arvalid;
    logic                  s0_arready;
    logic [ID_WIDTH-1:0]   s0_arid;
    logic [ADDR_WIDTH-1:0] s0_araddr;
    logic [7:0]            s0_arlen;
    logic [2:0]            s0_arsize;
    logic [1:0]            s0_arburst;
    logic                  s0_rvalid;
    logic                  s0_rready;
    logic [DATA_WIDTH-1:0] s0_rdata;
    logic [ID_WIDTH-1:0]   s0_rid;
    logic [1:0]            s0_rresp;
    logic                  s0_rlast;
    // requester 1 (DCache)
    logic                  s1_arvalid;
    logic                  s1_arready;
    logic [ID_WIDTH-1:0]   s1_arid;
    logic [ADDR_WIDTH-1:0] s1_araddr;
    logic [7:0]            s1_arlen;
    logic [2:0]            s1_arsize;
    logic [1:0]            s1_arburst;
    logic                  s1_rvalid;
    logic                  s1_rready;
    logic [DATA_WIDTH-1:0] s1_rdata;
    logic [ID_WIDTH-1:0]   s1_rid;
    logic [1:0]            s1_rresp;
    logic                  s1_rlast;
    // memory side
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport slave (
        input  s0_arvalid, s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_rready,
        input  s1_arvalid, s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s0_arready, s0_rvalid, s0_rdata, s0_rid, s0_rresp, s0_rlast,
        output s1_arready, s1_rvalid, s1_rdata, s1_rid, s1_rresp, s1_rlast,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s0_arvalid, s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_rready,
        output s1_arvalid, s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s0_arready, s0_rvalid, s0_rdata, s0_rid, s0_rresp, s0_rlast,
        input  s1_arready, s1_rvalid, s1_rdata, s1_rid, s1_rresp, s1_rlast,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-port AXI4 read arbiter: ICache (port 0) and DCache (port 1) share one
// memory-side AR/R port. One burst is outstanding at a time, grants rotate
// round-robin, and R beats are routed to the owner of the current burst.
// Burst-length and RID checks on the returned data set a sticky error flag.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : requester and memory-side AR/R channels (slave modport)
//   grant_owner   : port owning the current (or last) burst
//   busy          : arbiter is not idle
//   proto_err     : sticky protocol error, cleared only by reset
module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    axi_read_arbiter_if.slave   bus,
    output logic                grant_owner,
    output logic                busy,
    output logic                proto_err
);
    localparam int unsigned LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_en;
    logic                   r_rr_ptr;
    logic                   r_owner;
    logic                   r_proto_err;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic                   r_arvalid;
    logic [ID_WIDTH-1:0]    r_arid;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [LEN_WIDTH-1:0]   r_arlen;
    logic [2:0]             r_arsize;
    logic [1:0]             r_arburst;

    logic                   w_winner;
    logic                   w_grant;
    logic                   w_ar_hs;
    logic                   w_m_rready;
    logic                   w_s0_rvalid;
    logic                   w_s1_rvalid;
    logic                   w_r_hs;
    logic                   w_err;
    logic [ID_WIDTH-1:0]    w_win_arid;
    logic [ADDR_WIDTH-1:0]  w_win_araddr;
    logic [LEN_WIDTH-1:0]   w_win_arlen;
    logic [2:0]             w_win_arsize;
    logic [1:0]             w_win_arburst;

    // Winner selection: a lone requester wins; with two, the round-robin pointer decides
    always_comb begin
        w_winner      = bus.s1_arvalid;
        if (bus.s0_arvalid && bus.s1_arvalid) begin
            w_winner = r_rr_ptr;
        end
        w_win_arid    = bus.s0_arid;
        w_win_araddr  = bus.s0_araddr;
        w_win_arlen   = bus.s0_arlen;
        w_win_arsize  = bus.s0_arsize;
        w_win_arburst = bus.s0_arburst;
        if (w_winner) begin
            w_win_arid    = bus.s1_arid;
            w_win_araddr  = bus.s1_araddr;
            w_win_arlen   = bus.s1_arlen;
            w_win_arsize  = bus.s1_arsize;
            w_win_arburst = bus.s1_arburst;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus the combinational grant / R routing
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ar_hs     = 1'b0;
        w_m_rready  = 1'b0;
        w_s0_rvalid = 1'b0;
        w_s1_rvalid = 1'b0;
        case (r_state)
            IDLE: begin
                // r_en blocks any accept in the first cycle after reset release
                if (r_en && (bus.s0_arvalid || bus.s1_arvalid)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (r_arvalid && bus.m_axi_arready) begin
                    w_ar_hs     = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_m_rready  = r_owner ? bus.s1_rready : bus.s0_rready;
                w_s0_rvalid = !r_owner && bus.m_axi_rvalid;
                w_s1_rvalid = r_owner && bus.m_axi_rvalid;
                // Only rlast ends the burst, even if errors were flagged on the way
                if (bus.m_axi_rvalid && w_m_rready && bus.m_axi_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_r_hs = (r_state == DATA) && bus.m_axi_rvalid && w_m_rready;

    // Protocol checks: beat count vs. arlen, RID match, and stray data outside a burst
    always_comb begin
        w_err = 1'b0;
        if (w_r_hs) begin
            if (bus.m_axi_rlast != (r_beat_cnt == r_arlen)) begin
                w_err = 1'b1;
            end
            if (bus.m_axi_rid != r_arid) begin
                w_err = 1'b1;
            end
        end
        if (bus.m_axi_rvalid && (r_state != DATA)) begin
            w_err = 1'b1;
        end
    end

    // Grant, AR field and beat/error bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en        <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_proto_err <= 1'b0;
            r_beat_cnt  <= '0;
            r_arvalid   <= 1'b0;
            r_arid      <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_grant) begin
                r_owner    <= w_winner;
                r_arvalid  <= 1'b1;
                r_beat_cnt <= '0;
                r_arid     <= w_win_arid;
                r_araddr   <= w_win_araddr;
                r_arlen    <= w_win_arlen;
                r_arsize   <= w_win_arsize;
                r_arburst  <= w_win_arburst;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                if (bus.m_axi_rlast) begin
                    r_rr_ptr <= ~r_owner;
                end
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Requester-side outputs; R payload is broadcast, only rvalid is steered
    assign bus.s0_arready = w_grant && !w_winner;
    assign bus.s1_arready = w_grant && w_winner;
    assign bus.s0_rvalid  = w_s0_rvalid;
    assign bus.s1_rvalid  = w_s1_rvalid;
    assign bus.s0_rdata   = bus.m_axi_rdata;
    assign bus.s1_rdata   = bus.m_axi_rdata;
    assign bus.s0_rid     = bus.m_axi_rid;
    assign bus.s1_rid     = bus.m_axi_rid;
    assign bus.s0_rresp   = bus.m_axi_rresp;
    assign bus.s1_rresp   = bus.m_axi_rresp;
    assign bus.s0_rlast   = bus.m_axi_rlast;
    assign bus.s1_rlast   = bus.m_axi_rlast;

    // Memory-side outputs
    assign bus.m_axi_arid    = r_arid;
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arlen   = r_arlen;
    assign bus.m_axi_arsize  = r_arsize;
    assign bus.m_axi_arburst = r_arburst;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = w_m_rready;

    assign grant_owner = r_owner;
    assign busy        = (r_state != IDLE);
    assign proto_err   = r_proto_err;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter: reset, single burst, round-robin,
// AR stall, rready back-pressure, protocol errors, stray data, mid-burst reset.
module tb_axi_read_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 13;

    logic clk = 1'b0;
    logic reset_n;
    logic grant_owner;
    logic busy;
    logic proto_err;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .grant_owner(grant_owner),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.s0_arvalid = 1'b0; bus.s0_arid = '0; bus.s0_araddr = '0; bus.s0_arlen = '0;
        bus.s0_arsize = 3'd3;  bus.s0_arburst = 2'd1; bus.s0_rready = 1'b1;
        bus.s1_arvalid = 1'b0; bus.s1_arid = '0; bus.s1_araddr = '0; bus.s1_arlen = '0;
        bus.s1_arsize = 3'd3;  bus.s1_arburst = 2'd1; bus.s1_rready = 1'b1;
        bus.m_axi_arready = 1'b0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
    endtask

    // Leaves time at 2 ns after a rising edge with reset just released
    task automatic apply_reset;
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic drive_req(input bit port, input logic [IW-1:0] id,
                             input logic [AW-1:0] addr, input logic [7:0] len, input bit v);
        if (port) begin
            bus.s1_arid = id; bus.s1_araddr = addr; bus.s1_arlen = len; bus.s1_arvalid = v;
        end else begin
            bus.s0_arid = id; bus.s0_araddr = addr; bus.s0_arlen = len; bus.s0_arvalid = v;
        end
    endtask

    // Raise arvalid and wait (bounded) for the accepting edge
    task automatic accept(input bit port, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input bit hold, output bit ok);
        ok = 1'b0;
        drive_req(port, id, addr, len, 1'b1);
        for (int k = 0; k < 30 && !ok; k++) begin
            #1;
            if ((port ? bus.s1_arready : bus.s0_arready) === 1'b1) ok = 1'b1;
            tick();
        end
        if (!hold) drive_req(port, id, addr, len, 1'b0);
    endtask

    task automatic ar_hs;
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
    endtask

    // Memory returns beats 0..last_at; tallies what the owner / non-owner observe
    task automatic data_phase(input bit owner, input int last_at, input logic [IW-1:0] rid,
                              input bit toggle, output int c_own, output int leak,
                              output int bad_ready, output int bad_data, output bit done);
        int  i;
        bit  own_rdy;
        bit  hs;
        i = 0; done = 1'b0; c_own = 0; leak = 0; bad_ready = 0; bad_data = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = 64'hD0D0_0000_0000_0000 | 64'(i);
            bus.m_axi_rid    = rid;
            bus.m_axi_rresp  = 2'b00;
            bus.m_axi_rlast  = (i == last_at);
            own_rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
            // non-owner rready is the opposite so a wrong mux is visible
            if (owner) begin
                bus.s1_rready = own_rdy; bus.s0_rready = toggle ? !own_rdy : 1'b1;
            end else begin
                bus.s0_rready = own_rdy; bus.s1_rready = toggle ? !own_rdy : 1'b1;
            end
            #1;
            hs = (bus.m_axi_rready === 1'b1);
            if (bus.m_axi_rready !== own_rdy) bad_ready++;
            if ((owner ? bus.s0_rvalid : bus.s1_rvalid) !== 1'b0) leak++;
            if ((owner ? bus.s1_rvalid : bus.s0_rvalid) !== 1'b1) bad_data++;
            if (hs) begin
                c_own++;
                if ((owner ? bus.s1_rdata : bus.s0_rdata) !== (64'hD0D0_0000_0000_0000 | 64'(i)))
                    bad_data++;
            end
            tick();
            if (hs) begin
                if (i == last_at) done = 1'b1;
                i++;
            end
        end
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        bus.s0_rready = 1'b1; bus.s1_rready = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        drive_req(1'b0, 13'd1, 64'h40, 8'd0, 1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (grant_owner !== 1'b0) begin n_err++; $display("FAIL rst_owner got=%b exp=0", grant_owner); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_proto got=%b exp=0", proto_err); end
        n_vec++; if (bus.m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid got=%b exp=0", bus.m_axi_arvalid); end
        n_vec++; if (bus.m_axi_araddr !== 64'h0) begin n_err++; $display("FAIL rst_araddr got=%h exp=0", bus.m_axi_araddr); end
        n_vec++; if (bus.s0_arready !== 1'b0) begin n_err++; $display("FAIL rst_arready got=%b exp=0", bus.s0_arready); end
        n_vec++; if (bus.m_axi_arcache !== 4'b0011) begin n_err++; $display("FAIL arcache got=%h exp=3", bus.m_axi_arcache); end
        #1; reset_n = 1'b1; #1;
        n_vec++; if (bus.s0_arready !== 1'b0) begin n_err++; $display("FAIL first_cycle_arready got=%b exp=0", bus.s0_arready); end
        tick();
        n_vec++; if (bus.s0_arready !== 1'b1) begin n_err++; $display("FAIL en_arready got=%b exp=1", bus.s0_arready); end
        bus.s0_arvalid = 1'b0; #1;
        n_vec++; if (bus.s0_arready !== 1'b0) begin n_err++; $display("FAIL drop_arready got=%b exp=0", bus.s0_arready); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_no_grant busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        bit ok, done; int c, lk, br, bd;
        accept(1'b0, 13'd5, 64'h1000, 8'd7, 1'b0, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_accept got=%b exp=1", ok); end
        n_vec++; if (bus.m_axi_arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid got=%b exp=1", bus.m_axi_arvalid); end
        n_vec++; if (bus.m_axi_araddr !== 64'h1000) begin n_err++; $display("FAIL single_araddr got=%h exp=1000", bus.m_axi_araddr); end
        n_vec++; if (bus.m_axi_arlen !== 8'd7) begin n_err++; $display("FAIL single_arlen got=%0d exp=7", bus.m_axi_arlen); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
        ar_hs();
        n_vec++; if (bus.m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL single_arvalid_drop got=%b exp=0", bus.m_axi_arvalid); end
        data_phase(1'b0, 7, 13'd5, 1'b0, c, lk, br, bd, done);
        n_vec++; if (c !== 8) begin n_err++; $display("FAIL single_beats got=%0d exp=8", c); end
        n_vec++; if ((lk + br + bd) !== 0) begin n_err++; $display("FAIL single_routing got=%0d exp=0", lk + br + bd); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL single_proto got=%b exp=0", proto_err); end
    endtask

    task automatic test_round_robin;
        bit done; int c, lk, br, bd;
        apply_reset();
        tick();
        drive_req(1'b0, 13'd1, 64'hA000, 8'd1, 1'b1);
        drive_req(1'b1, 13'd2, 64'hB000, 8'd1, 1'b1);
        #1;
        n_vec++; if ({bus.s1_arready, bus.s0_arready} !== 2'b01) begin n_err++; $display("FAIL rr_first got=%b exp=01", {bus.s1_arready, bus.s0_arready}); end
        tick();
        n_vec++; if (bus.m_axi_araddr !== 64'hA000) begin n_err++; $display("FAIL rr_addr0 got=%h exp=a000", bus.m_axi_araddr); end
        #1;
        n_vec++; if (bus.s1_arready !== 1'b0) begin n_err++; $display("FAIL rr_no_grant_busy got=%b exp=0", bus.s1_arready); end
        tick();
        ar_hs();
        data_phase(1'b0, 1, 13'd1, 1'b0, c, lk, br, bd, done);
        n_vec++; if (c !== 2 || (lk + br + bd) !== 0) begin n_err++; $display("FAIL rr_burst0 got=%0d/%0d exp=2/0", c, lk + br + bd); end
        #1;
        n_vec++; if ({bus.s1_arready, bus.s0_arready} !== 2'b10) begin n_err++; $display("FAIL rr_second got=%b exp=10", {bus.s1_arready, bus.s0_arready}); end
        tick();
        n_vec++; if (grant_owner !== 1'b1 || bus.m_axi_araddr !== 64'hB000 || bus.m_axi_arid !== 13'd2)
            begin n_err++; $display("FAIL rr_grant1 got=%b/%h/%0d exp=1/b000/2", grant_owner, bus.m_axi_araddr, bus.m_axi_arid); end
        ar_hs();
        data_phase(1'b1, 1, 13'd2, 1'b0, c, lk, br, bd, done);
        n_vec++; if (c !== 2 || (lk + br + bd) !== 0) begin n_err++; $display("FAIL rr_burst1 got=%0d/%0d exp=2/0", c, lk + br + bd); end
        #1;
        n_vec++; if ({bus.s1_arready, bus.s0_arready} !== 2'b01) begin n_err++; $display("FAIL rr_third got=%b exp=01", {bus.s1_arready, bus.s0_arready}); end
        tick();
        n_vec++; if (grant_owner !== 1'b0) begin n_err++; $display("FAIL rr_grant0_again got=%b exp=0", grant_owner); end
        bus.s0_arvalid = 1'b0; bus.s1_arvalid = 1'b0;
        ar_hs();
        data_phase(1'b0, 1, 13'd1, 1'b0, c, lk, br, bd, done);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rr_end got=%b/%b exp=1/0", done, busy); end
    endtask

    task automatic test_ar_stall;
        bit ok, done; int c, lk, br, bd, bad;
        bad = 0;
        accept(1'b0, 13'd9, 64'h2000, 8'd0, 1'b0, ok);
        bus.s0_araddr = 64'hDEAD_0000; bus.s0_arlen = 8'd5; bus.s0_arid = 13'd3;
        for (int k = 0; k < 5; k++) begin
            if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== 64'h2000 ||
                bus.m_axi_arlen !== 8'd0 || bus.m_axi_arid !== 13'd9) bad++;
            tick();
        end
        n_vec++; if (ok !== 1'b1 || bad !== 0) begin n_err++; $display("FAIL stall_stable got=%b/%0d exp=1/0", ok, bad); end
        ar_hs();
        n_vec++; if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL stall_hs got=%b/%b exp=0/1", bus.m_axi_arvalid, busy); end
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
        n_vec++; if (bus.m_axi_arvalid !== 1'b0) begin n_err++; $display("FAIL stall_single_ar got=%b exp=0", bus.m_axi_arvalid); end
        data_phase(1'b0, 0, 13'd9, 1'b0, c, lk, br, bd, done);
        n_vec++; if (c !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL stall_data got=%0d/%b exp=1/0", c, busy); end
    endtask

    task automatic test_rready_toggle;
        bit ok, done; int c, lk, br, bd;
        accept(1'b1, 13'd2, 64'h3000, 8'd3, 1'b0, ok);
        ar_hs();
        data_phase(1'b1, 3, 13'd2, 1'b1, c, lk, br, bd, done);
        n_vec++; if (c !== 4 || done !== 1'b1) begin n_err++; $display("FAIL toggle_beats got=%0d exp=4", c); end
        n_vec++; if (br !== 0) begin n_err++; $display("FAIL toggle_rready_mirror got=%0d exp=0", br); end
        n_vec++; if (lk !== 0) begin n_err++; $display("FAIL toggle_s0_rvalid got=%0d exp=0", lk); end
        n_vec++; if (bd !== 0) begin n_err++; $display("FAIL toggle_data got=%0d exp=0", bd); end
    endtask

    task automatic test_proto_err;
        bit ok, done; int c, lk, br, bd;
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_pre got=%b exp=0", proto_err); end
        accept(1'b0, 13'd4, 64'h4000, 8'd7, 1'b0, ok);
        ar_hs();
        data_phase(1'b0, 5, 13'd4, 1'b0, c, lk, br, bd, done);
        n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_early_last got=%b exp=1", proto_err); end
        n_vec++; if (c !== 6 || busy !== 1'b0) begin n_err++; $display("FAIL perr_exit got=%0d/%b exp=6/0", c, busy); end
        accept(1'b1, 13'd7, 64'h5000, 8'd1, 1'b0, ok);
        ar_hs();
        data_phase(1'b1, 1, 13'd6, 1'b0, c, lk, br, bd, done);
        n_vec++; if (proto_err !== 1'b1 || c !== 2 || busy !== 1'b0)
            begin n_err++; $display("FAIL perr_rid got=%b/%0d/%b exp=1/2/0", proto_err, c, busy); end
    endtask

    task automatic test_stray_rvalid;
        apply_reset();
        tick();
        bus.m_axi_rvalid = 1'b1;
        #1;
        n_vec++; if ({bus.m_axi_rready, bus.s0_rvalid, bus.s1_rvalid} !== 3'b000)
            begin n_err++; $display("FAIL stray_route got=%b exp=000", {bus.m_axi_rready, bus.s0_rvalid, bus.s1_rvalid}); end
        tick();
        bus.m_axi_rvalid = 1'b0;
        n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL stray_proto got=%b exp=1", proto_err); end
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        apply_reset();
        tick();
        accept(1'b1, 13'd3, 64'h6000, 8'd3, 1'b1, ok);
        ar_hs();
        bus.m_axi_rvalid = 1'b1; bus.m_axi_rid = 13'd3;
        #1;
        n_vec++; if (bus.s1_rvalid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_in_data got=%b/%b exp=1/1", bus.s1_rvalid, busy); end
        reset_n = 1'b0;
        #1;
        bus.m_axi_rvalid = 1'b0;
        n_vec++; if ({busy, grant_owner, bus.s1_rvalid, bus.m_axi_rready, bus.m_axi_arvalid} !== 5'b00000)
            begin n_err++; $display("FAIL mid_async got=%b exp=00000", {busy, grant_owner, bus.s1_rvalid, bus.m_axi_rready, bus.m_axi_arvalid}); end
        n_vec++; if (bus.m_axi_araddr !== 64'h0 || bus.m_axi_arid !== 13'd0)
            begin n_err++; $display("FAIL mid_ar_clear got=%h/%0d exp=0/0", bus.m_axi_araddr, bus.m_axi_arid); end
        tick();
        reset_n = 1'b1;
        #1;
        n_vec++; if (bus.s1_arready !== 1'b0) begin n_err++; $display("FAIL mid_first_cycle got=%b exp=0", bus.s1_arready); end
        tick();
        n_vec++; if (bus.s1_arready !== 1'b1) begin n_err++; $display("FAIL mid_then_ready got=%b exp=1", bus.s1_arready); end
        bus.s1_arvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ar_stall();
        test_rready_toggle();
        test_proto_err();
        test_stray_rvalid();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
